// File: rtl/inst_rom_port_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_port_if
// Description : Instruction-fetch bus between the core (master) and the
//               instruction ROM port (slave): chip-enable, byte address,
//               returned instruction, stall request and misalign flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_rom_port_if;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        misalign_o;

  modport master (
    output ce_i,
    output addr_i,
    input  inst_o,
    input  stallreq_o,
    input  misalign_o
  );

  modport slave (
    input  ce_i,
    input  addr_i,
    output inst_o,
    output stallreq_o,
    output misalign_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_rom_port.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_port
// Description : Responder side of the instruction-fetch port. Word-organised
//               instruction memory with programmable wait states, stall
//               request to the core, and a boot-loader write port.
//               Optional macro INST_ROM_PARITY_EN adds a per-word even-parity
//               bit, checked when a word is served.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_port #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_port_if.slave    fetch_if,
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i,
  output logic              load_ready_o,
  output logic              parity_err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic              load_ready_q;
  logic [ADDR_W-1:0] idx;
  logic              aligned;
  logic              in_range;
  logic              valid;

  assign idx      = fetch_if.addr_i[ADDR_W+1:2];
  assign aligned  = (fetch_if.addr_i[1:0] == 2'b00);
  assign in_range = (fetch_if.addr_i[31:ADDR_W+2] == '0);
  assign valid    = fetch_if.ce_i & aligned & in_range;

  assign fetch_if.misalign_o = fetch_if.ce_i & ~aligned;
  assign load_ready_o        = load_ready_q;

  // Loader writes into the array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_valid_i) mem_q[load_addr_i] <= load_data_i;
  end

  // One-cycle acknowledge following every accepted loader write.
  always_ff @(posedge clk) begin
    if (rst) load_ready_q <= 1'b0;
    else     load_ready_q <= load_valid_i;
  end

`ifdef INST_ROM_PARITY_EN
  logic par_mem_q [DEPTH];

  // Even-parity bit is computed once, when the loader writes the word.
  always_ff @(posedge clk) begin
    if (load_valid_i) par_mem_q[load_addr_i] <= ^load_data_i;
  end
`endif

  generate
    if (WAIT_CYCLES == 0) begin : g_comb
      logic [31:0] word;
      assign word = mem_q[idx];
      assign fetch_if.stallreq_o = 1'b0;
`ifdef INST_ROM_PARITY_EN
      logic perr;
      assign perr              = valid & ((^word) != par_mem_q[idx]);
      assign parity_err_o      = perr;
      assign fetch_if.inst_o   = (valid & ~perr) ? word : NOP_WORD;
`else
      assign parity_err_o      = 1'b0;
      assign fetch_if.inst_o   = valid ? word : NOP_WORD;
`endif
    end else begin : g_wait
      typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
      } state_t;

      localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

      state_t      state_q;
      logic [3:0]  cnt_q;
      logic [31:0] last_q;
      logic [31:0] pend_q;
      logic [31:0] inst_q;
      logic        ld;
      logic        eff_idle;
      logic        start;
      logic        waiting;
      logic        serve;
      logic        done;
      logic        inval;
      logic        perr;

      assign ld = load_valid_i;

      // HOLD on a changed/dropped fetch and WAIT on a redirect both fall back
      // to IDLE decisions in the same cycle, so no dead cycle is inserted.
      assign eff_idle = (state_q == S_IDLE)
                      | ((state_q == S_WAIT) & (~valid | (fetch_if.addr_i != pend_q)))
                      | ((state_q == S_HOLD) & (~fetch_if.ce_i | (fetch_if.addr_i != last_q)));

      assign start   = ~ld & eff_idle & valid & (fetch_if.addr_i != last_q);
      assign waiting = ~ld & (state_q == S_WAIT) & ~eff_idle;
      assign serve   = ~ld & valid & (fetch_if.addr_i == last_q)
                     & (eff_idle | (state_q == S_HOLD));
      // Word is latched at the end of the last stall cycle.
      assign done    = (start & (WAIT_CYCLES == 1)) | (waiting & (cnt_q == 4'd1));
      // Drop the served-address tag if the loader rewrites the word behind it.
      assign inval   = ld & ((load_addr_i == idx) | (load_addr_i == last_q[ADDR_W+1:2]));

`ifdef INST_ROM_PARITY_EN
      logic ipar_q;

      // Stored parity travels alongside the latched word.
      always_ff @(posedge clk) begin
        if (rst)       ipar_q <= 1'b0;
        else if (done) ipar_q <= par_mem_q[idx];
      end

      assign perr = serve & ((^inst_q) != ipar_q);
`else
      assign perr = 1'b0;
`endif

      assign parity_err_o        = perr;
      assign fetch_if.stallreq_o = ld ? fetch_if.ce_i : (start | waiting);
      assign fetch_if.inst_o     = (serve & ~perr) ? inst_q : NOP_WORD;

      // Fetch FSM: wait-state countdown, word latch and served-address tag.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          last_q  <= 32'hFFFF_FFFF;
          pend_q  <= 32'hFFFF_FFFF;
          inst_q  <= NOP_WORD;
        end else if (ld) begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          if (inval) last_q <= 32'hFFFF_FFFF;
        end else if (done) begin
          inst_q  <= mem_q[idx];
          last_q  <= fetch_if.addr_i;
          cnt_q   <= 4'd0;
          state_q <= S_HOLD;
        end else if (start) begin
          pend_q  <= fetch_if.addr_i;
          cnt_q   <= CNT_INIT;
          state_q <= S_WAIT;
        end else if (waiting) begin
          cnt_q   <= cnt_q - 4'd1;
        end else if (serve) begin
          state_q <= S_HOLD;
        end else begin
          state_q <= S_IDLE;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_port
// Description : Directed self-checking bench for inst_rom_port with default
//               parameters (ADDR_W=10, WAIT_CYCLES=2, NOP_WORD=0). The parity
//               scenario is compiled in only with INST_ROM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_port;
  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        parity_err;
  int          n_checks;
  int          n_fail;

  inst_rom_port_if bus ();

  inst_rom_port #(
    .ADDR_W      (10),
    .WAIT_CYCLES (2),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_if     (bus),
    .load_valid_i (load_valid),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .parity_err_o (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Apply fetch inputs, then let combinational outputs settle mid-cycle.
  task automatic drive(input logic ce, input logic [31:0] addr);
    bus.ce_i   = ce;
    bus.addr_i = addr;
    #2;
  endtask

  task automatic outs(input string tag, input logic [31:0] inst, input logic stall);
    chk({tag, ".inst"},  bus.inst_o,     inst);
    chk({tag, ".stall"}, bus.stallreq_o, stall);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    bus.ce_i = 1'b0; bus.addr_i = 32'h0;
    go(); go();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    outs("reset", 32'h0, 1'b0);
    chk("reset.misalign", bus.misalign_o, 1'b0);
    chk("reset.ready", load_ready, 1'b0);
    chk("reset.perr", parity_err, 1'b0);

    // Load program words with ce low: no stall requested.
    load_valid = 1'b1; load_addr = 10'd0; load_data = 32'h3401_1100;
    drive(1'b0, 32'h0);
    chk("load0.stall", bus.stallreq_o, 1'b0);
    go(); load_addr = 10'd1;  load_data = 32'h3402_0020; #2; chk("load1.ready", load_ready, 1'b1);
    go(); load_addr = 10'd16; load_data = 32'hA5A5_0016; #2;
    go(); load_addr = 10'd3;  load_data = 32'h1234_5678; #2;
    go(); load_valid = 1'b0; #2; chk("load3.ready", load_ready, 1'b1);
    go(); #2; chk("idle.ready", load_ready, 1'b0);

    // Fetch addr 0: two stall cycles then the word.
    go(); drive(1'b1, 32'h0); outs("f0.c0", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h0); outs("f0.c1", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h0); outs("f0.c2", 32'h3401_1100, 1'b0);

    // Fetch addr 4: two more stall cycles, then held for three cycles.
    go(); drive(1'b1, 32'h4); outs("f4.c0", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h4); outs("f4.c1", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h4); outs("f4.c2", 32'h3402_0020, 1'b0);
    go(); drive(1'b1, 32'h4); outs("f4.rep1", 32'h3402_0020, 1'b0);
    go(); drive(1'b1, 32'h4); outs("f4.rep2", 32'h3402_0020, 1'b0);

    // Redirect 8 -> 0x40 mid-stall: three stall cycles, then mem[16].
    go(); drive(1'b1, 32'h8);  outs("redir.c0", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h40); outs("redir.c1", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h40); outs("redir.c2", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h40); outs("redir.c3", 32'hA5A5_0016, 1'b0);

    // Misaligned and out-of-range fetches.
    go(); drive(1'b1, 32'h6);
    outs("misal", 32'h0, 1'b0);
    chk("misal.flag", bus.misalign_o, 1'b1);
    go(); drive(1'b1, 32'h0001_0000);
    outs("oor", 32'h0, 1'b0);
    chk("oor.flag", bus.misalign_o, 1'b0);

    // Reach HOLD on addr 4, then rewrite mem[1] underneath it.
    go(); drive(1'b1, 32'h4); outs("h4.c0", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h4); outs("h4.c1", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h4); outs("h4.c2", 32'h3402_0020, 1'b0);
    go(); load_valid = 1'b1; load_addr = 10'd1; load_data = 32'hDEAD_BEEF;
    drive(1'b1, 32'h4); outs("ld.c0", 32'h0, 1'b1);
    go(); load_valid = 1'b0;
    drive(1'b1, 32'h4); outs("ld.c1", 32'h0, 1'b1);
    chk("ld.ready", load_ready, 1'b1);
    go(); drive(1'b1, 32'h4); outs("ld.c2", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h4); outs("ld.c3", 32'hDEAD_BEEF, 1'b0);

    // Reset in the middle of WAIT aborts the fetch.
    go(); drive(1'b1, 32'h0); outs("rw.c0", 32'h0, 1'b1);
    go(); rst = 1'b1; drive(1'b1, 32'h0);
    go(); rst = 1'b0; drive(1'b0, 32'h0);
    outs("rw.after", 32'h0, 1'b0);
    chk("rw.ready", load_ready, 1'b0);
    // Served-address tag was cleared, memory was not: full refetch of addr 0.
    go(); drive(1'b1, 32'h0); outs("rf.c0", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h0); outs("rf.c1", 32'h0, 1'b1);
    go(); drive(1'b1, 32'h0); outs("rf.c2", 32'h3401_1100, 1'b0);
    chk("rf.perr", parity_err, 1'b0);

`ifdef INST_ROM_PARITY_EN
    // Corrupt the stored parity of word 3 and fetch it.
    dut.par_mem_q[3] = ~dut.par_mem_q[3];
    go(); drive(1'b1, 32'hC); outs("par.c0", 32'h0, 1'b1);
    go(); drive(1'b1, 32'hC); outs("par.c1", 32'h0, 1'b1);
    go(); drive(1'b1, 32'hC); outs("par.c2", 32'h0, 1'b0);
    chk("par.err", parity_err, 1'b1);
`endif

    go(); drive(1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/inst_rom_port.md
Name: inst_rom_port

Overview:
- Responder side of the core's instruction-fetch port. Serves ce_i/addr_i, which are driven by the core's ROM chip-enable and ROM address outputs, and returns inst_o.
- Holds a word-organised instruction memory.
- Inserts programmable wait states and requests a pipeline stall through stallreq_o, which feeds the core's stall controller alongside the ID and EX stall requests.
- Provides a boot-loader write port so a test program can be loaded after reset without recompiling.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, stall cycles per new fetch (0..15); 0 selects combinational read.
- NOP_WORD, 32'h0000_0000, word returned when ce_i is low, while stalling, or on an out-of-range or misaligned fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ce_i  in  1  fetch enable from the core.
- addr_i  in  32  byte address of the fetch.
- inst_o  out  32  instruction word to IF/ID.
- stallreq_o  out  1  stall request to the stall controller.
- misalign_o  out  1  addr_i[1:0] != 0 while ce_i is high.
- load_valid_i  in  1  loader write request.
- load_addr_i  in  ADDR_W  loader word index.
- load_data_i  in  32  loader write data.
- load_ready_o  out  1  loader write accepted this cycle.
- parity_err_o  out  1  parity error (optional feature only).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - inst_o = NOP_WORD; stallreq_o = 0; misalign_o = 0; load_ready_o = 0; parity_err_o = 0.
  - FSM = IDLE; wait counter = 0; last-served address register = 32'hFFFF_FFFF.
  - Memory contents are not cleared by reset.
- Word index: addr_i[ADDR_W+1:2]. Out of range when addr_i[31:ADDR_W+2] != 0; an out-of-range fetch returns NOP_WORD with no stall.
- Misaligned fetch (addr_i[1:0] != 0):
  - misalign_o = 1 (combinational).
  - inst_o = NOP_WORD, no stall.
- WAIT_CYCLES = 0:
  - inst_o = mem[index] combinationally when ce_i = 1, otherwise NOP_WORD.
  - stallreq_o is tied to 0.
  - FSM unused except the LOAD rule below.
- WAIT_CYCLES > 0, FSM states IDLE, WAIT, HOLD:
  - IDLE: when ce_i = 1, the address is valid, and addr_i != last address → go to WAIT, cnt = WAIT_CYCLES-1, stallreq_o = 1 in this same cycle (combinational). If ce_i = 1 and addr_i == last address → HOLD.
  - WAIT: stallreq_o = 1; inst_o = NOP_WORD; cnt decrements each cycle. When cnt = 0 on a clock edge: latch mem[index] into the output register, update the last address, go to HOLD.
  - HOLD: inst_o = the registered word; stallreq_o = 0. If addr_i changes or ce_i falls → IDLE with no dead cycle, and the IDLE conditions are evaluated combinationally in the same cycle.
  - If addr_i changes during WAIT, the counter restarts from WAIT_CYCLES-1 for the new address (a branch redirect mid-stall).
  - Total stall per new address = WAIT_CYCLES cycles; the word is visible on inst_o in the cycle stallreq_o drops.
- Loader:
  - load_valid_i = 1 writes mem[load_addr_i] on the clock edge; load_ready_o = 1 in the following cycle (one-cycle pulse per write).
  - While load_valid_i = 1, stallreq_o = 1 whenever ce_i = 1, and the FSM is forced to IDLE.
  - Invalidate the last-served address when load_addr_i equals the current fetch index, so a rewritten word is refetched rather than served stale.
- Simultaneous events:
  - A load and a fetch to the same index in the same cycle: the load wins, and the fetch completes later with the new data.
  - rst asserted mid-WAIT aborts the fetch and clears the outputs on the next edge.

Optional Feature:
- Macro INST_ROM_PARITY_EN.
- When defined:
  - Each word stores an even-parity bit computed at load time.
  - On a served fetch, a parity mismatch sets parity_err_o = 1 for that cycle and inst_o = NOP_WORD.
  - Verification uses a debug-only backdoor that flips the stored parity bit.
- When undefined: no parity storage, and parity_err_o is tied to 0.

Test Plan:
- WAIT_CYCLES = 2; load mem[0] = 32'h3401_1100 and mem[1] = 32'h3402_0020; fetch addr 0 → stallreq_o high 2 cycles, then inst_o = 32'h3401_1100; addr 4 → 2 more stall cycles, then inst_o = 32'h3402_0020.
- Repeat fetch of addr 4 for 3 cycles → no stall; inst_o stays 32'h3402_0020.
- Change addr from 8 to 32'h0000_0040 after one WAIT cycle → counter restarts; total stall = 3 cycles; inst_o = mem[16].
- addr 32'h0000_0006 → misalign_o = 1, inst_o = 0, stallreq_o = 0; addr 32'h0001_0000 with ADDR_W = 10 → inst_o = 0, no stall.
- Load mem[1] = 32'hDEAD_BEEF while fetching addr 4 in HOLD → stallreq_o high during the load, refetch stalls 2 cycles, inst_o = 32'hDEAD_BEEF; rst mid-WAIT → outputs reach reset values after one edge.
- INST_ROM_PARITY_EN defined, flip the parity bit of word 3 via the backdoor, fetch addr 12 → parity_err_o = 1, inst_o = 0.
